// File: rtl/axi4_pkg.sv
// Shared AXI4 types, widths and burst address helpers used by the read slave
// and the DMA masters.
package axi4_pkg;

    localparam int AXI4_MAX_BEATS = 256;
    localparam int LEN_BITS       = $clog2(AXI4_MAX_BEATS);
    localparam int SIZE_BITS      = 3;
    localparam int BURST_BITS     = 2;
    localparam int RESP_BITS      = 2;
    localparam int AXI4_ADDR_MAX  = 64;

    typedef logic [LEN_BITS-1:0]      len_t;
    typedef logic [SIZE_BITS-1:0]     size_t;
    typedef logic [AXI4_ADDR_MAX-1:0] axi_addr_t;

    typedef enum logic [BURST_BITS-1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2,
        BURST_RSVD  = 2'd3
    } burst_t;

    typedef enum logic [RESP_BITS-1:0] {
        RESP_OKAY   = 2'd0,
        RESP_EXOKAY = 2'd1,
        RESP_SLVERR = 2'd2,
        RESP_DECERR = 2'd3
    } resp_t;

    // Callers truncate the result to their own address width, so the sum wraps modulo 2^ADDR_WIDTH.
    function automatic axi_addr_t axi4_next_addr(input axi_addr_t addr, input size_t size,
                                                 input len_t len, input burst_t burst);
        axi_addr_t bytes_v;
        axi_addr_t boundary_v;
        axi_addr_t base_v;
        axi_addr_t next_v;
        bytes_v    = axi_addr_t'(1'b1) << size;
        boundary_v = (axi_addr_t'(len) + axi_addr_t'(1'b1)) << size;
        base_v     = addr & ~(boundary_v - axi_addr_t'(1'b1));
        case (burst)
            BURST_FIXED: next_v = addr;
            BURST_INCR:  next_v = (addr & ~(bytes_v - axi_addr_t'(1'b1))) + bytes_v;
            BURST_WRAP:  next_v = base_v + ((addr + bytes_v - base_v) & (boundary_v - axi_addr_t'(1'b1)));
            default:     next_v = addr;
        endcase
        return next_v;
    endfunction

    function automatic logic axi4_wrap_len_ok(input len_t len);
        logic ok_v;
        case (len)
            8'd1, 8'd3, 8'd7, 8'd15: ok_v = 1'b1;
            default:                 ok_v = 1'b0;
        endcase
        return ok_v;
    endfunction

endpackage

// File: rtl/axi4_burst_addr_gen.sv
// Burst address sequencer: holds the current beat address, beat counter and
// last-beat flag; load starts a burst, advance steps to the next beat.
module axi4_burst_addr_gen
    import axi4_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  advance,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  len_t                  start_len,
    input  size_t                 start_size,
    input  burst_t                start_burst,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [ADDR_WIDTH-1:0] next_addr,
    output logic                  last
);

    logic [ADDR_WIDTH-1:0] addr_r;
    len_t                  beat_r;
    len_t                  len_r;
    size_t                 size_r;
    burst_t                burst_r;
    logic                  last_r;

    assign next_addr = ADDR_WIDTH'(axi4_next_addr(axi_addr_t'(addr_r), size_r, len_r, burst_r));
    assign addr      = addr_r;
    assign last      = last_r;

    // Burst context and beat tracking; the counter never exceeds len so len=255 cannot overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r  <= {ADDR_WIDTH{1'b0}};
            beat_r  <= 8'd0;
            len_r   <= 8'd0;
            size_r  <= 3'd0;
            burst_r <= BURST_FIXED;
            last_r  <= 1'b0;
        end else if (load) begin
            addr_r  <= start_addr;
            beat_r  <= 8'd0;
            len_r   <= start_len;
            size_r  <= start_size;
            burst_r <= start_burst;
            last_r  <= (start_len == 8'd0);
        end else if (advance) begin
            addr_r  <= next_addr;
            beat_r  <= beat_r + 8'd1;
            last_r  <= ((beat_r + 8'd1) == len_r);
        end
    end

endmodule

// File: rtl/axi4_read_slave.sv
// AXI4 read responder serving one burst at a time from a 1-cycle-latency SRAM,
// answering illegal requests and out-of-range beats with SLVERR.
module axi4_read_slave
    import axi4_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int MEM_BYTES  = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ID_WIDTH-1:0]   s_axi_arid,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [LEN_BITS-1:0]   s_axi_arlen,
    input  logic [SIZE_BITS-1:0]  s_axi_arsize,
    input  logic [BURST_BITS-1:0] s_axi_arburst,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [ID_WIDTH-1:0]   s_axi_rid,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [RESP_BITS-1:0]  s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int BUS_SIZE = $clog2(DATA_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] BUS_MASK  = ADDR_WIDTH'((DATA_WIDTH / 8) - 1);
    localparam logic [ADDR_WIDTH-1:0] MEM_LIMIT = ADDR_WIDTH'(MEM_BYTES);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_DATA = 1'b1} state_t;

    state_t                state_r;
    logic                  arready_r;
    logic                  rvalid_r;
    logic [ID_WIDTH-1:0]   rid_r;
    resp_t                 rresp_r;
    logic                  burst_err_r;

    burst_t                ar_burst_s;
    logic                  ar_hs_s;
    logic                  adv_s;
    logic                  ar_unaligned_s;
    logic                  req_err_s;
    logic                  first_oor_s;
    logic                  next_oor_s;
    logic [ADDR_WIDTH-1:0] cur_addr_s;
    logic [ADDR_WIDTH-1:0] next_addr_s;
    logic                  last_s;
    logic                  mem_rd_en_s;
    logic [ADDR_WIDTH-1:0] mem_addr_s;
    logic [DATA_WIDTH-1:0] rdata_s;

    assign ar_burst_s     = burst_t'(s_axi_arburst);
    assign ar_hs_s        = (state_r == ST_IDLE) && s_axi_arvalid && arready_r;
    assign adv_s          = (state_r == ST_DATA) && s_axi_rready && !last_s;
    assign ar_unaligned_s = (s_axi_araddr & ((ADDR_WIDTH'(1'b1) << s_axi_arsize) - ADDR_WIDTH'(1'b1)))
                            != {ADDR_WIDTH{1'b0}};
    assign req_err_s      = (ar_burst_s == BURST_RSVD)
                         || (s_axi_arsize > SIZE_BITS'(BUS_SIZE))
                         || ((ar_burst_s == BURST_WRAP) && (!axi4_wrap_len_ok(s_axi_arlen) || ar_unaligned_s));
    assign first_oor_s    = (s_axi_araddr >= MEM_LIMIT);
    assign next_oor_s     = (next_addr_s >= MEM_LIMIT);

    axi4_burst_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .clk         (clk),
        .rst         (rst),
        .load        (ar_hs_s),
        .advance     (adv_s),
        .start_addr  (s_axi_araddr),
        .start_len   (s_axi_arlen),
        .start_size  (s_axi_arsize),
        .start_burst (ar_burst_s),
        .addr        (cur_addr_s),
        .next_addr   (next_addr_s),
        .last        (last_s)
    );

    // SRAM strobe must coincide with the accepting handshake so data lines up with rvalid next cycle.
    always_comb begin
        mem_rd_en_s = 1'b0;
        mem_addr_s  = cur_addr_s & ~BUS_MASK;
        if (state_r == ST_IDLE) begin
            mem_addr_s  = s_axi_araddr & ~BUS_MASK;
            mem_rd_en_s = ar_hs_s && !req_err_s && !first_oor_s;
        end else if (s_axi_rready) begin
            mem_addr_s  = next_addr_s & ~BUS_MASK;
            mem_rd_en_s = !last_s && !burst_err_r && !next_oor_s;
        end else begin
            mem_addr_s  = cur_addr_s & ~BUS_MASK;
            mem_rd_en_s = 1'b0;
        end
    end

    // Error beats never read the SRAM, so their stale data is blanked.
    always_comb begin
        rdata_s = mem_rdata;
        if (rresp_r == RESP_SLVERR) begin
            rdata_s = {DATA_WIDTH{1'b0}};
        end else begin
            rdata_s = mem_rdata;
        end
    end

    // Burst FSM with registered handshake, id and response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            arready_r   <= 1'b0;
            rvalid_r    <= 1'b0;
            rid_r       <= {ID_WIDTH{1'b0}};
            rresp_r     <= RESP_OKAY;
            burst_err_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (ar_hs_s) begin
                        state_r     <= ST_DATA;
                        arready_r   <= 1'b0;
                        rvalid_r    <= 1'b1;
                        rid_r       <= s_axi_arid;
                        burst_err_r <= req_err_s;
                        rresp_r     <= (req_err_s || first_oor_s) ? RESP_SLVERR : RESP_OKAY;
                    end else begin
                        arready_r   <= 1'b1;
                    end
                end
                ST_DATA: begin
                    if (s_axi_rready) begin
                        if (last_s) begin
                            state_r   <= ST_IDLE;
                            rvalid_r  <= 1'b0;
                            arready_r <= 1'b1;
                            rresp_r   <= RESP_OKAY;
                        end else begin
                            rresp_r   <= (burst_err_r || next_oor_s) ? RESP_SLVERR : RESP_OKAY;
                        end
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    arready_r <= 1'b0;
                    rvalid_r  <= 1'b0;
                end
            endcase
        end
    end

    assign s_axi_arready = arready_r;
    assign s_axi_rvalid  = rvalid_r;
    assign s_axi_rid     = rid_r;
    assign s_axi_rresp   = rresp_r;
    assign s_axi_rlast   = rvalid_r && last_s;
    assign s_axi_rdata   = rdata_s;
    assign mem_rd_en     = mem_rd_en_s;
    assign mem_addr      = mem_addr_s;

endmodule

// File: tb/tb_axi4_read_slave.sv
// Scoreboard bench for axi4_read_slave: expected beats and SRAM reads are queued
// when a burst is issued and compared as the DUT produces them.
module tb_axi4_read_slave;
    import axi4_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 4;
    localparam int MB = 4096;

    logic          clk = 1'b0;
    logic          rst;
    logic [IW-1:0] s_axi_arid;
    logic [AW-1:0] s_axi_araddr;
    logic [7:0]    s_axi_arlen;
    logic [2:0]    s_axi_arsize;
    logic [1:0]    s_axi_arburst;
    logic          s_axi_arvalid;
    logic          s_axi_arready;
    logic [IW-1:0] s_axi_rid;
    logic [DW-1:0] s_axi_rdata;
    logic [1:0]    s_axi_rresp;
    logic          s_axi_rlast;
    logic          s_axi_rvalid;
    logic          s_axi_rready;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata;

    always #5 clk = ~clk;

    axi4_read_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MEM_BYTES(MB)) dut (
        .clk(clk), .rst(rst),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready), .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata),
        .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid),
        .s_axi_rready(s_axi_rready), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
    );

    // Backing SRAM: word i holds i.
    logic [31:0] mem [0:1023];
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= (mem_addr < MB) ? mem[mem_addr[11:2]] : 32'hDEAD_BEEF;
    end

    typedef struct packed {
        logic [IW-1:0] id;
        logic [31:0]   data;
        logic [1:0]    resp;
        logic          last;
    } beat_t;

    beat_t       exp_q[$];
    logic [31:0] rd_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int beats_seen = 0;
    int reads_seen = 0;
    int rlast_hs_cyc = -10;
    int rready_mode = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Independent closed-form address of beat i.
    function automatic logic [31:0] beat_addr(input logic [31:0] a, input int sz, input int len,
                                              input int bt, input int i);
        logic [31:0] bytes_v, bnd, base;
        bytes_v = 32'd1 << sz;
        case (bt)
            1: return (i == 0) ? a : ((a / bytes_v) * bytes_v + 32'(i) * bytes_v);
            2: begin
                bnd  = 32'(len + 1) * bytes_v;
                base = a - (a % bnd);
                return base + ((a - base + 32'(i) * bytes_v) % bnd);
            end
            default: return a;
        endcase
    endfunction

    task automatic push_burst(input logic [IW-1:0] id, input logic [31:0] a, input int len,
                              input int sz, input int bt);
        logic  berr, err;
        logic [31:0] ba;
        beat_t b;
        berr = (bt == 3) || (sz > 2) ||
               ((bt == 2) && !(len == 1 || len == 3 || len == 7 || len == 15)) ||
               ((bt == 2) && ((a % (32'd1 << sz)) != 32'd0));
        for (int i = 0; i <= len; i++) begin
            ba   = beat_addr(a, sz, len, bt, i);
            err  = berr || (ba >= MB);
            b.id = id;
            b.data = err ? 32'd0 : mem[ba[11:2]];
            b.resp = err ? 2'd2 : 2'd0;
            b.last = (i == len);
            exp_q.push_back(b);
            if (!err) rd_q.push_back(ba & 32'hFFFF_FFFC);
        end
    endtask

    task automatic send_ar(input logic [IW-1:0] id, input logic [31:0] a, input int len,
                           input int sz, input int bt, output int hs_cyc);
        logic got;
        s_axi_arid = id; s_axi_araddr = a; s_axi_arlen = 8'(len);
        s_axi_arsize = 3'(sz); s_axi_arburst = 2'(bt); s_axi_arvalid = 1'b1;
        push_burst(id, a, len, sz, bt);
        got = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (s_axi_arready) begin got = 1'b1; break; end
        end
        if (!got) check("ar_timeout", 64'd1, 64'd0);
        hs_cyc = cyc + 1;
        @(posedge clk); #1;
    endtask

    task automatic drain(input int limit);
        logic done;
        done = 1'b0;
        for (int k = 0; k < limit; k++) begin
            @(posedge clk); #2;
            if (exp_q.size() == 0 && rd_q.size() == 0 && !s_axi_rvalid) begin done = 1'b1; break; end
        end
        if (!done) begin
            check("drain_timeout", 64'd1, 64'd0);
            exp_q.delete(); rd_q.delete();
        end
    endtask

    initial forever begin
        @(posedge clk); cyc++;
    end

    // rready driver: always high, or the 1,0,0,1 stall pattern.
    initial begin
        int idx;
        logic [3:0] pat;
        idx = 0; pat = 4'b1001; s_axi_rready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (rready_mode == 1) begin s_axi_rready = pat[3 - (idx % 4)]; idx++; end
            else begin s_axi_rready = 1'b1; idx = 0; end
        end
    end

    // Monitor: scoreboard compare of R beats and SRAM reads, plus stall stability.
    initial begin
        beat_t e; logic [31:0] ea; logic prev_stall; logic [38:0] prev_bus;
        prev_stall = 1'b0; prev_bus = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (mem_rd_en) begin
                    reads_seen++;
                    if (rd_q.size() == 0) check("rd_unexpected", 64'(mem_addr), 64'hFFFF_FFFF);
                    else begin ea = rd_q.pop_front(); check("mem_addr", 64'(mem_addr), 64'(ea)); end
                end
                if (prev_stall && s_axi_rvalid)
                    check("r_stable", 64'({s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast}), 64'(prev_bus));
                prev_stall = s_axi_rvalid && !s_axi_rready;
                prev_bus   = {s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast};
                if (s_axi_rvalid && s_axi_rready) begin
                    beats_seen++;
                    if (s_axi_rlast) rlast_hs_cyc = cyc + 1;
                    if (exp_q.size() == 0) check("r_unexpected", 64'(s_axi_rdata), 64'hFFFF_FFFF);
                    else begin
                        e = exp_q.pop_front();
                        check("rdata", 64'(s_axi_rdata), 64'(e.data));
                        check("rresp", 64'(s_axi_rresp), 64'(e.resp));
                        check("rlast", 64'(s_axi_rlast), 64'(e.last));
                        check("rid",   64'(s_axi_rid),   64'(e.id));
                    end
                end
            end
        end
    end

    initial begin
        int hs1, hs2, b0, r0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'(i);
        rst = 1'b1; s_axi_arvalid = 1'b0; s_axi_arid = '0; s_axi_araddr = '0;
        s_axi_arlen = '0; s_axi_arsize = '0; s_axi_arburst = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_arready", 64'(s_axi_arready), 64'd0);
        check("rst_rvalid",  64'(s_axi_rvalid),  64'd0);
        check("rst_rlast",   64'(s_axi_rlast),   64'd0);
        check("rst_rid",     64'(s_axi_rid),     64'd0);
        check("rst_rresp",   64'(s_axi_rresp),   64'd0);
        check("rst_mem_rd",  64'(mem_rd_en),     64'd0);
        rst = 1'b0;

        // INCR 0x100, first beat at T+1 then back-to-back beats
        send_ar(4'h5, 32'h100, 3, 2, 1, hs1);
        s_axi_arvalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("incr_rvalid_streak", 64'(s_axi_rvalid), 64'd1);
        end
        drain(50);

        // WRAP 0x38 len 3: reads 0x38,0x3C,0x30,0x34
        send_ar(4'h3, 32'h38, 3, 2, 2, hs1);
        s_axi_arvalid = 1'b0;
        drain(50);

        // FIXED 0x20 under rready stalls
        rready_mode = 1;
        send_ar(4'h7, 32'h20, 2, 2, 0, hs1);
        s_axi_arvalid = 1'b0;
        drain(100);
        rready_mode = 0;

        // Reserved burst type: all SLVERR, no SRAM reads
        r0 = reads_seen;
        send_ar(4'h9, 32'h40, 2, 2, 3, hs1);
        s_axi_arvalid = 1'b0;
        drain(50);
        check("rsvd_no_reads", 64'(reads_seen - r0), 64'd0);

        // WRAP with illegal len
        r0 = reads_seen;
        send_ar(4'hA, 32'h40, 2, 2, 2, hs1);
        s_axi_arvalid = 1'b0;
        drain(50);
        check("wraplen_no_reads", 64'(reads_seen - r0), 64'd0);

        // Crossing the end of memory: OKAY, OKAY, SLVERR, SLVERR
        r0 = reads_seen;
        send_ar(4'h2, MB - 8, 3, 2, 1, hs1);
        s_axi_arvalid = 1'b0;
        drain(50);
        check("oor_reads", 64'(reads_seen - r0), 64'd2);

        // Back-to-back: len 0 then len 255 with arvalid held
        b0 = beats_seen;
        send_ar(4'h1, 32'h10, 0, 2, 1, hs1);
        send_ar(4'h2, 32'h0, 255, 2, 1, hs2);
        s_axi_arvalid = 1'b0;
        check("b2b_ar_gap", 64'(hs2), 64'(rlast_hs_cyc + 1));
        drain(400);
        check("b2b_beats", 64'(beats_seen - b0), 64'd257);

        // Reset during beat 5 of a len 15 burst
        b0 = beats_seen;
        send_ar(4'h4, 32'h0, 15, 2, 1, hs1);
        s_axi_arvalid = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #2;
            if (beats_seen - b0 >= 5) break;
        end
        check("rst_mid_reached", 64'(beats_seen - b0), 64'd5);
        rst = 1'b1;
        @(posedge clk); #2;
        check("rst_mid_rvalid",  64'(s_axi_rvalid),  64'd0);
        check("rst_mid_arready", 64'(s_axi_arready), 64'd0);
        rst = 1'b0;
        exp_q.delete(); rd_q.delete();
        send_ar(4'h6, 32'h200, 1, 2, 1, hs1);
        s_axi_arvalid = 1'b0;
        drain(50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axi4_read_slave.md
Name: axi4_read_slave

Overview:
AXI4 read-channel responder (AR in, R out) that serves bursts from a synchronous single-port SRAM read interface with 1-cycle read latency. It is the memory-side counterpart of the DMA controller's read master and is used as the on-chip source memory and as the bench target model. It handles one burst at a time and implements FIXED/INCR/WRAP address generation. Out-of-range, illegal and reserved requests are answered with SLVERR beats.

Parameters:
ADDR_WIDTH, 32, byte address width of araddr and mem_addr
DATA_WIDTH, 32, R data width in bits; power of 2, 32..256
ID_WIDTH, 4, width of arid/rid
MEM_BYTES, 4096, size of the backing memory in bytes; power of 2; addresses >= MEM_BYTES are out of range

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
s_axi_arid  in  ID_WIDTH  burst ID
s_axi_araddr  in  ADDR_WIDTH  start byte address
s_axi_arlen  in  axi4_pkg::LEN_BITS  beats minus 1
s_axi_arsize  in  axi4_pkg::SIZE_BITS  log2 bytes per beat
s_axi_arburst  in  axi4_pkg::BURST_BITS  burst_t (FIXED/INCR/WRAP; 3 reserved)
s_axi_arvalid  in  1  AR valid
s_axi_arready  out  1  AR ready
s_axi_rid  out  ID_WIDTH  echoed arid
s_axi_rdata  out  DATA_WIDTH  read data (full bus width)
s_axi_rresp  out  axi4_pkg::RESP_BITS  OKAY or SLVERR
s_axi_rlast  out  1  last beat
s_axi_rvalid  out  1  R valid
s_axi_rready  in  1  R ready
mem_rd_en  out  1  SRAM read strobe
mem_addr  out  ADDR_WIDTH  SRAM byte address, aligned to DATA_WIDTH/8
mem_rdata  in  DATA_WIDTH  SRAM data; valid the cycle after mem_rd_en and held until the next mem_rd_en

Behaviour:
- Clock is clk. Reset is rst: synchronous, active-high.
- Reset values: arready=0, rvalid=0, rlast=0, rid=0, rresp=OKAY, mem_rd_en=0, beat counter=0, FSM=IDLE. Asserting rst mid-burst aborts the burst; all outputs take reset values on the next edge.
- FSM:
  - IDLE: arready=1 combinationally. On arvalid&&arready, latch id/addr/len/size/burst, issue the beat-0 read in the same cycle (mem_rd_en=1, mem_addr from araddr), then go to DATA.
  - DATA: arready=0, rvalid=1, rdata=mem_rdata (masked to 0 on error beats).
    - On rvalid&&rready with beat!=len: advance the address, issue the next read in the same cycle, beat++, so rvalid stays high and the next data appears the following cycle.
    - On the handshake with rlast: return to IDLE.
    - While rready=0, all R outputs hold stable and mem_rd_en=0.
- Latency: AR handshake at cycle T gives the first rvalid at T+1. Sustained throughput is 1 beat/cycle with rready held high. The next AR is accepted the cycle after the rlast handshake, so there is a minimum 1 idle cycle between bursts.
- rlast=1 exactly when beat==len. rid is constant for the whole burst.
- Address generation (byte address, bytes=1<<size):
  - FIXED: address unchanged.
  - INCR: addr+bytes; the low bits of the first beat are unaligned, later beats are aligned to size.
  - WRAP: boundary = (len+1)*bytes, base = addr & ~(boundary-1); next = base + ((addr+bytes-base) mod boundary).
  - mem_addr = addr with its low log2(DATA_WIDTH/8) bits cleared.
- Errors: the whole burst returns SLVERR with rdata=0 and mem_rd_en never asserted if any of the following holds:
  - burst==3 (reserved); the address is held as FIXED.
  - size > log2(DATA_WIDTH/8).
  - WRAP with len not in {1,3,7,15}.
  - WRAP with an unaligned start address.
- A beat whose address >= MEM_BYTES gets SLVERR, rdata=0 and no mem_rd_en. Other beats of the same burst remain OKAY.
- Address arithmetic is ADDR_WIDTH wide and wraps modulo 2^ADDR_WIDTH. 4 KB boundary crossing is not checked.
- Beat counter is LEN_BITS wide; len=255 gives 256 beats with no overflow.

Decomposition:
- axi4_pkg: fix len_t/size_t to full widths ([LEN_BITS-1:0], [SIZE_BITS-1:0]).
- axi4_pkg: add function axi4_next_addr(addr, size, len, burst) implementing the FIXED/INCR/WRAP rules above.
- axi4_pkg: add function axi4_wrap_len_ok(len).
- axi4_pkg: add AXI4_MAX_BEATS=256.
- One natural sub-module: axi4_burst_addr_gen (registered address, beat counter and last flag; load/advance inputs), reusable by the DMA read and write masters.

Test Plan:
- INCR, araddr=0x100, len=3, size=2, rready=1, mem preloaded word[i]=i: R beats 0x40..0x43 on 4 consecutive cycles starting T+1, OKAY, rlast on beat 3, rid echoed.
- WRAP, araddr=0x38, len=3, size=2: mem_addr sequence 0x38, 0x3C, 0x30, 0x34; all OKAY.
- FIXED, araddr=0x20, len=2, with rready toggled 1,0,0,1,...: mem_addr stays 0x20 for all 3 beats; R outputs stable while rready=0; no extra mem_rd_en.
- Errors:
  - arburst=3 -> len+1 beats of SLVERR, rdata=0, mem_rd_en never high.
  - INCR with araddr=MEM_BYTES-8, len=3, size=2 -> beats OKAY, OKAY, SLVERR, SLVERR.
- Back-to-back: arvalid held high with two queued bursts (len=0, len=255): second arready exactly 1 cycle after the first rlast handshake; 256 beats delivered; rlast only on the final beat.
- rst asserted during beat 5 of a len=15 burst -> next cycle rvalid=0, arready=0; after rst release, arready=1 and a new burst completes normally.
